// File: rtl/front_end_ctrl.sv
// Front-end pipeline controller: start-up sequencing, redirect/flush handling and stall chain.
// Optional perf counters are enabled by defining QU_FE_CTRL_PERF_CNT_EN.
`ifndef QU_PC_WIDTH
`define QU_PC_WIDTH 32
`endif

module front_end_ctrl #(
    parameter int PC_WIDTH     = `QU_PC_WIDTH,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                branch,
    input  logic                jump,
    input  logic                exception,
    input  logic [PC_WIDTH-1:0] branch_pc,
    input  logic [PC_WIDTH-1:0] jump_pc,
    input  logic [PC_WIDTH-1:0] exception_pc,
    input  logic                stall,
    input  logic                rob_full,
    input  logic                res_st_full,
    input  logic                fifo_mp_rn_full,
    input  logic                fifo_id_mp_full,
    input  logic                fifo_if_id_full,
    output logic                if_en,
    output logic                id_en,
    output logic                if_stall,
    output logic                id_stall,
    output logic                mp_stall,
    output logic                rn_stall,
    output logic                flush,
    output logic                redirect,
    output logic [PC_WIDTH-1:0] pc_override
`ifdef QU_FE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_redirect_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, FLUSH} state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [3:0]            cnt_reg;
    logic [3:0]            cnt_next;
    logic                  redirect_req;
    logic                  redirect_next;
    logic [PC_WIDTH-1:0]   target_pc;
    logic                  stage_active;
    logic [2:0]            fifo_full_vec;
    logic [3:0]            stall_raw;
    logic [3:0]            stall_next;
    logic                  if_en_next;
    logic                  id_en_next;

    // Exception wins over branch, branch over jump; only one target is ever issued.
    always_comb begin
        redirect_req = exception | branch | jump;
        if (exception)
            target_pc = exception_pc;
        else if (branch)
            target_pc = branch_pc;
        else
            target_pc = jump_pc;
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        redirect_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = WARMUP;
            end
            WARMUP, RUN: begin
                if (redirect_req) begin
                    state_next    = FLUSH;
                    cnt_next      = FLUSH_LOAD;
                    redirect_next = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (redirect_req) begin
                    cnt_next      = FLUSH_LOAD;
                    redirect_next = 1'b1;
                end else if (cnt_reg == 4'd0) begin
                    state_next = WARMUP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Stall chain indexed rn(0), mp(1), id(2), if(3); each stage stalls when the
    // stage behind it stalls and the FIFO between them is full.
    assign fifo_full_vec = {fifo_if_id_full, fifo_id_mp_full, fifo_mp_rn_full};
    assign stall_raw[0]  = stall | rob_full | res_st_full;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_stall_chain
            assign stall_raw[gi] = stall | (stall_raw[gi-1] & fifo_full_vec[gi-1]);
        end
    endgenerate

    // Outputs describe the state being entered, so a redirect suppresses stalls.
    assign stage_active = (state_next == WARMUP) || (state_next == RUN);
    assign stall_next   = stage_active ? stall_raw : 4'b0000;
    assign if_en_next   = (state_next == WARMUP) || ((state_next == RUN) && !stall_next[3]);
    assign id_en_next   = (state_next == RUN) && !stall_next[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            if_en       <= 1'b0;
            id_en       <= 1'b0;
            rn_stall    <= 1'b0;
            mp_stall    <= 1'b0;
            id_stall    <= 1'b0;
            if_stall    <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            pc_override <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if_en     <= if_en_next;
            id_en     <= id_en_next;
            rn_stall  <= stall_next[0];
            mp_stall  <= stall_next[1];
            id_stall  <= stall_next[2];
            if_stall  <= stall_next[3];
            flush     <= (state_next == FLUSH);
            redirect  <= redirect_next;
            if (redirect_next)
                pc_override <= target_pc;
        end
    end

`ifdef QU_FE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirect_cnt <= 32'd0;
            perf_stall_cnt    <= 32'd0;
        end else begin
            if (redirect_next)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            if ((state_reg == RUN) && (rn_stall | mp_stall | id_stall | if_stall))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_front_end_ctrl.sv
// Directed bench for front_end_ctrl: start-up, stall chain, redirect priority, flush and reset.
module tb_front_end_ctrl;

    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst, start, branch, jump, exception;
    logic [PW-1:0] branch_pc, jump_pc, exception_pc;
    logic          stall, rob_full, res_st_full;
    logic          fifo_mp_rn_full, fifo_id_mp_full, fifo_if_id_full;
    logic          if_en, id_en, if_stall, id_stall, mp_stall, rn_stall, flush, redirect;
    logic [PW-1:0] pc_override;
`ifdef QU_FE_CTRL_PERF_CNT_EN
    logic [31:0]   perf_redirect_cnt, perf_stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    front_end_ctrl #(.PC_WIDTH(PW), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .branch(branch), .jump(jump), .exception(exception),
        .branch_pc(branch_pc), .jump_pc(jump_pc), .exception_pc(exception_pc),
        .stall(stall), .rob_full(rob_full), .res_st_full(res_st_full),
        .fifo_mp_rn_full(fifo_mp_rn_full), .fifo_id_mp_full(fifo_id_mp_full),
        .fifo_if_id_full(fifo_if_id_full),
        .if_en(if_en), .id_en(id_en), .if_stall(if_stall), .id_stall(id_stall),
        .mp_stall(mp_stall), .rn_stall(rn_stall), .flush(flush), .redirect(redirect),
        .pc_override(pc_override)
`ifdef QU_FE_CTRL_PERF_CNT_EN
        , .perf_redirect_cnt(perf_redirect_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // {if_en, id_en, flush, redirect, if_stall, id_stall, mp_stall, rn_stall}
    function automatic logic [7:0] outs();
        return {if_en, id_en, flush, redirect, if_stall, id_stall, mp_stall, rn_stall};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; branch = 1'b0; jump = 1'b0; exception = 1'b0;
        branch_pc = '0; jump_pc = '0; exception_pc = '0;
        stall = 1'b0; rob_full = 1'b0; res_st_full = 1'b0;
        fifo_mp_rn_full = 1'b0; fifo_id_mp_full = 1'b0; fifo_if_id_full = 1'b0;
        tick();
        chk("reset_outs", 32'(outs()), 32'h00);
        chk("reset_pc", pc_override, 32'h0);

        // Requests and start present during reset are ignored
        start = 1'b1; branch = 1'b1; branch_pc = 32'h55; rob_full = 1'b1;
        tick();
        chk("reset_ignore_outs", 32'(outs()), 32'h00);
        chk("reset_ignore_pc", pc_override, 32'h0);

        rst = 1'b0; branch = 1'b0; rob_full = 1'b0;
        tick();
        chk("warmup", 32'(outs()), 32'b1000_0000);
        start = 1'b0;
        tick();
        chk("run_entry", 32'(outs()), 32'b1100_0000);
        tick();
        chk("run_hold_after_start_low", 32'(outs()), 32'b1100_0000);

        rob_full = 1'b1; fifo_mp_rn_full = 1'b1;
        tick();
        chk("stall_rob_mp", 32'(outs()), 32'b1100_0011);
        rob_full = 1'b0; fifo_mp_rn_full = 1'b0; stall = 1'b1;
        tick();
        chk("stall_global", 32'(outs()), 32'b0000_1111);
        stall = 1'b0; rob_full = 1'b1;
        fifo_mp_rn_full = 1'b1; fifo_id_mp_full = 1'b1; fifo_if_id_full = 1'b1;
        tick();
        chk("stall_full_chain", 32'(outs()), 32'b0000_1111);
        rob_full = 1'b0; res_st_full = 1'b1; fifo_mp_rn_full = 1'b0;
        tick();
        chk("stall_chain_broken", 32'(outs()), 32'b1100_0001);
        res_st_full = 1'b0; fifo_id_mp_full = 1'b0; fifo_if_id_full = 1'b0;
        tick();
        chk("stall_release", 32'(outs()), 32'b1100_0000);

        // Branch redirect from RUN, three flush cycles, then WARMUP and RUN
        branch = 1'b1; branch_pc = 32'h100;
        tick();
        chk("br_redirect", 32'(outs()), 32'b0011_0000);
        chk("br_pc", pc_override, 32'h100);
        branch = 1'b0; branch_pc = 32'h999;
        tick();
        chk("br_flush2", 32'(outs()), 32'b0010_0000);
        chk("br_pc_hold", pc_override, 32'h100);
        tick();
        chk("br_flush3", 32'(outs()), 32'b0010_0000);
        tick();
        chk("br_warmup", 32'(outs()), 32'b1000_0000);
        tick();
        chk("br_run", 32'(outs()), 32'b1100_0000);

        // Exception beats branch; redirect beats a concurrent stall
        exception = 1'b1; exception_pc = 32'h200; branch = 1'b1; branch_pc = 32'h100; stall = 1'b1;
        tick();
        chk("exc_redirect", 32'(outs()), 32'b0011_0000);
        chk("exc_pc", pc_override, 32'h200);
        exception = 1'b0; branch = 1'b0; stall = 1'b0;
        tick();
        chk("exc_single_pulse", 32'(outs()), 32'b0010_0000);

        // Counter is now 1: a jump reloads it for three further flush cycles
        jump = 1'b1; jump_pc = 32'h40;
        tick();
        chk("jmp_redirect", 32'(outs()), 32'b0011_0000);
        chk("jmp_pc", pc_override, 32'h40);
        jump = 1'b0;
        tick();
        chk("jmp_flush2", 32'(outs()), 32'b0010_0000);
        tick();
        chk("jmp_flush3", 32'(outs()), 32'b0010_0000);
        tick();
        chk("jmp_warmup", 32'(outs()), 32'b1000_0000);

        // Branch beats jump, redirect taken from WARMUP
        branch = 1'b1; branch_pc = 32'h88; jump = 1'b1; jump_pc = 32'h44;
        tick();
        chk("bj_redirect", 32'(outs()), 32'b0011_0000);
        chk("bj_pc", pc_override, 32'h88);
        branch = 1'b0; jump = 1'b0;
        tick();
        chk("bj_flush2", 32'(outs()), 32'b0010_0000);
`ifdef QU_FE_CTRL_PERF_CNT_EN
        chk("perf_redirect", perf_redirect_cnt, 32'd4);
        chk("perf_stall", perf_stall_cnt, 32'd4);
`endif

        // Reset in the middle of FLUSH with a request pending
        rst = 1'b1; branch = 1'b1; branch_pc = 32'h300;
        tick();
        chk("rst_flush_outs", 32'(outs()), 32'h00);
        chk("rst_flush_pc", pc_override, 32'h0);
`ifdef QU_FE_CTRL_PERF_CNT_EN
        chk("rst_perf_redirect", perf_redirect_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_ignores_branch", 32'(outs()), 32'h00);
        chk("idle_pc", pc_override, 32'h0);
        branch = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/front_end_ctrl.md
FRONT_END_CTRL -- requirements
Module: front_end_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default QU_PC_WIDTH, width of redirect target PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 3, cycles the front end is held in flush after a redirect; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; releases the front end from IDLE.
REQ-006 SHALL have ports branch, jump, exception  input  1 each  redirect requests, sampled every cycle.
REQ-007 SHALL have ports branch_pc, jump_pc, exception_pc  input  PC_WIDTH each  targets for the matching request.
REQ-008 SHALL have ports stall, rob_full, res_st_full, fifo_mp_rn_full, fifo_id_mp_full, fifo_if_id_full  input  1 each  back-pressure sources.
REQ-009 SHALL have ports if_en, id_en  output  1  stage enables for IF and ID.
REQ-010 SHALL have ports if_stall, id_stall, mp_stall, rn_stall  output  1  per-stage stall.
REQ-011 SHALL have port flush  output  1  high while in FLUSH.
REQ-012 SHALL have ports redirect  output  1 and pc_override  output  PC_WIDTH  one-cycle redirect strobe with target.

Function
REQ-013 SHALL implement FSM states IDLE, WARMUP, RUN, FLUSH.
REQ-014 IDLE: if_en=id_en=0; start=1 -> WARMUP next cycle.
REQ-015 WARMUP: if_en=1, id_en=0 for exactly one cycle -> RUN.
REQ-016 RUN: if_en=!if_stall, id_en=!id_stall; stays in RUN absent a redirect.
REQ-017 Any of exception/branch/jump high in WARMUP or RUN SHALL cause: next cycle state=FLUSH, redirect=1 for one cycle, pc_override = target of winner.
REQ-018 Redirect priority SHALL be exception > branch > jump when requests coincide; only one target is issued.
REQ-019 FLUSH: flush=1, if_en=id_en=0; a down-counter loads FLUSH_CYCLES-1 on entry; at 0 -> WARMUP.
REQ-020 A redirect request during FLUSH SHALL reload the counter, pulse redirect, and update pc_override per REQ-018.
REQ-021 rn_stall SHALL be registered (one-cycle latency) from stall | rob_full | res_st_full.
REQ-022 mp_stall SHALL be registered from stall | (rn_stall_next & fifo_mp_rn_full); id_stall from stall | (mp_stall_next & fifo_id_mp_full); if_stall from stall | (id_stall_next & fifo_if_id_full), where *_next is the value being registered this cycle.
REQ-023 Stalls SHALL be forced 0 in IDLE and FLUSH; redirect in RUN SHALL take precedence over stall.
REQ-024 pc_override SHALL hold its last value when redirect=0.
REQ-025 start deasserting after leaving IDLE SHALL have no effect.

Reset
REQ-026 rst=1 SHALL, at the next posedge, force state=IDLE, counter=0, and all outputs 0 (including pc_override), regardless of current state, including mid-FLUSH.
REQ-027 Redirect/stall inputs present during rst SHALL be ignored.

Configuration
REQ-028 With QU_FE_CTRL_PERF_CNT_EN defined, SHALL add outputs perf_redirect_cnt and perf_stall_cnt (32-bit each): count redirect pulses and RUN cycles with any stall high, wrapping at 2^32, cleared by rst.
REQ-029 Without QU_FE_CTRL_PERF_CNT_EN, these ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-030 Reset, start=1 at cycle 0 -> cycle 1 if_en=1,id_en=0; cycle 2 if_en=id_en=1.
REQ-031 RUN, branch=1 branch_pc=0x100 one cycle -> next cycle redirect=1, pc_override=0x100, flush=1 for 3 cycles, then WARMUP, RUN.
REQ-032 RUN, exception (0x200) and branch (0x100) same cycle -> pc_override=0x200, single redirect pulse.
REQ-033 FLUSH counter=1, jump=1 jump_pc=0x40 -> redirect pulse, pc_override=0x40, flush lasts 3 further cycles.
REQ-034 RUN, rob_full=1 with fifo_mp_rn_full=1, others 0 -> one cycle later rn_stall=mp_stall=1, id_stall=if_stall=0, if_en=1.
REQ-035 rst asserted mid-FLUSH -> next cycle all outputs 0, state IDLE; with macro, perf counters read 0.
